// File: rtl/mapper_pkg.sv
// Shared constants and entry type for the CPU-to-SDRAM memory mapper.
// Optional write protect is enabled by defining MAPPER_WP_EN.
package mapper_pkg;
  localparam logic [5:0] MAPPER_CTRL_OFFSET = 6'h20;
  localparam int PAGE_BITS = 13;
  localparam int OFFSET_BITS = 12;

  typedef struct packed {
    logic                 wp;
    logic [PAGE_BITS-1:0] page;
  } map_entry_t;
endpackage

// File: rtl/mapper_regfile.sv
// Page table, shadow/pending staging for atomic 13-bit commits, control register and read mux.
// MAPPER_WP_EN: high-byte bit7 is stored as the entry write-protect bit.
module mapper_regfile
  import mapper_pkg::*;
#(
  parameter int NUM_ENTRIES = 16
) (
  input  logic       i_clk,
  input  logic       i_arst_n,
  input  logic       i_cs,
  input  logic       i_rwb,
  input  logic [5:0] i_addr,
  input  logic [7:0] i_data,
  output logic [7:0] o_data,
  input  logic [3:0] i_sel_idx,
  output map_entry_t o_sel_entry,
  output logic       o_map_en,
  input  logic       i_wp_set
);

  map_entry_t r_table [NUM_ENTRIES];
  logic [7:0] r_shadow;
  logic       r_pending;
  logic       r_map_en;
  logic       r_wp_fault;

  logic       w_wr;
  logic       w_ctrl;
  logic [3:0] w_idx;
  logic       w_wp_bit;
  map_entry_t w_rd_entry;

  assign w_wr   = i_cs & ~i_rwb;
  assign w_ctrl = (i_addr == MAPPER_CTRL_OFFSET);
  assign w_idx  = i_addr[4:1];

`ifdef MAPPER_WP_EN
  logic w_unused;
  assign w_wp_bit = i_data[7];
  assign w_unused = ^i_data[6:5];
`else
  logic w_unused;
  assign w_wp_bit = 1'b0;
  assign w_unused = ^i_data[7:5];
`endif

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        r_table[i].wp   <= 1'b0;
        r_table[i].page <= PAGE_BITS'(i);
      end
      r_shadow   <= 8'h00;
      r_pending  <= 1'b0;
      r_map_en   <= 1'b0;
      r_wp_fault <= 1'b0;
    end else begin
      if (w_wr && !i_addr[5]) begin
        if (!i_addr[0]) begin
          r_shadow  <= i_data;
          r_pending <= 1'b1;
        end else begin
          // High-byte write commits the whole entry in one edge, so translation never sees half a page.
          r_table[w_idx].page <= {i_data[4:0], r_shadow};
          r_table[w_idx].wp   <= w_wp_bit;
          r_pending           <= 1'b0;
        end
      end
      if (w_wr && w_ctrl) r_map_en <= i_data[0];
      // A new fault outranks a same-cycle clear so no protected write goes unreported.
      if (i_wp_set) r_wp_fault <= 1'b1;
      else if (w_wr && w_ctrl && i_data[2]) r_wp_fault <= 1'b0;
    end
  end

  always_comb begin
    w_rd_entry = r_table[w_idx];
    o_data     = 8'h00;
    if (i_cs) begin
      if (!i_addr[5]) begin
        o_data = i_addr[0] ? {w_rd_entry.wp, 2'b00, w_rd_entry.page[12:8]}
                           : w_rd_entry.page[7:0];
      end else if (w_ctrl) begin
        o_data = {5'b00000, r_wp_fault, r_pending, r_map_en};
      end
    end
  end

  assign o_sel_entry = r_table[i_sel_idx];
  assign o_map_en    = r_map_en;

endmodule

// File: rtl/memory_mapper.sv
// Translates 16-bit CPU addresses into SDRAM addresses via a 16-entry 4 KiB page table.
// Define MAPPER_WP_EN to enable per-page write protect (o_wr_block and wp_fault).
module memory_mapper #(
  parameter int PAGE_BITS   = 13,
  parameter int NUM_ENTRIES = 16
) (
  input  logic                                       i_clk,
  input  logic                                       i_arst_n,
  input  logic                                       i_cs,
  input  logic                                       i_rwb,
  input  logic [5:0]                                 i_addr,
  input  logic [7:0]                                 i_data,
  output logic [7:0]                                 o_data,
  input  logic [15:0]                                i_cpu_addr,
  input  logic                                       i_mem_cs,
  output logic [PAGE_BITS+mapper_pkg::OFFSET_BITS-1:0] o_map_addr,
  output logic                                       o_wr_block
);
  import mapper_pkg::*;

  localparam int ADDR_W = PAGE_BITS + OFFSET_BITS;

  map_entry_t w_sel_entry;
  logic       w_map_en;
  logic       w_wr_block;

  mapper_regfile #(
    .NUM_ENTRIES(NUM_ENTRIES)
  ) u_regfile (
    .i_clk      (i_clk),
    .i_arst_n   (i_arst_n),
    .i_cs       (i_cs),
    .i_rwb      (i_rwb),
    .i_addr     (i_addr),
    .i_data     (i_data),
    .o_data     (o_data),
    .i_sel_idx  (i_cpu_addr[15:12]),
    .o_sel_entry(w_sel_entry),
    .o_map_en   (w_map_en),
    .i_wp_set   (w_wr_block)
  );

  always_comb begin
    if (w_map_en) o_map_addr = ADDR_W'({w_sel_entry.page, i_cpu_addr[OFFSET_BITS-1:0]});
    else          o_map_addr = ADDR_W'(i_cpu_addr);
  end

`ifdef MAPPER_WP_EN
  assign w_wr_block = w_map_en & i_mem_cs & ~i_rwb & w_sel_entry.wp;
`else
  logic w_unused;
  assign w_wr_block = 1'b0;
  assign w_unused   = i_mem_cs ^ w_sel_entry.wp;
`endif

  assign o_wr_block = w_wr_block;

endmodule

// File: doc/memory_mapper.md
MEMORY_MAPPER -- requirements
Module: memory_mapper

Interface
REQ-001 SHALL have parameter PAGE_BITS, default 13, meaning physical page-number width; physical address width = PAGE_BITS+12.
REQ-002 SHALL have parameter NUM_ENTRIES, default 16, meaning the number of 4 KiB CPU pages; fixed by the 16-bit CPU address.
REQ-003 Port i_clk, input, 1: the single clock (CPU clock domain).
REQ-004 Port i_arst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 Port i_cs, input, 1: register window select (CPU 0x0a00-0x0a20).
REQ-006 Port i_rwb, input, 1: 1 = read, 0 = write.
REQ-007 Port i_addr, input, 6: register offset (cpu_addr[5:0]).
REQ-008 Port i_data, input, 8: CPU write data.
REQ-009 Port o_data, output, 8: register read data.
REQ-010 Port i_cpu_addr, input, 16: CPU address to translate.
REQ-011 Port i_mem_cs, input, 1: CPU access targets mapped memory (SDRAM select).
REQ-012 Port o_map_addr, output, 25: translated address to the SDRAM adapter.
REQ-013 Port o_wr_block, output, 1: suppress the current memory write (write protect).

Function
REQ-014 Register write SHALL occur on the rising edge of i_clk when i_cs=1 and i_rwb=0.
REQ-015 Offset 2n (n<16) write SHALL load an 8-bit shadow register and set pending; the entry SHALL be unchanged.
REQ-016 Offset 2n+1 write SHALL commit entry n = {i_data[4:0], shadow} atomically in that cycle and clear pending.
REQ-017 Offset 2n+1 write without a prior low write SHALL commit the current shadow value (last written, or 0x00 after reset).
REQ-018 Two successive low writes SHALL leave the last value in the shadow (last wins).
REQ-019 Offset 0x20 SHALL be control: bit0 map_en (R/W), bit1 pending (RO), bit2 wp_fault (W1C), bits 7:3 read 0.
REQ-020 Reads SHALL be combinational, zero latency: 2n returns entry[7:0]; 2n+1 returns {wp, 2'b0, entry[12:8]}; the shadow is never visible.
REQ-021 Offsets 0x21-0x3f SHALL read 0x00 and ignore writes; o_data SHALL be 0x00 when i_cs=0.
REQ-022 With map_en=1: o_map_addr = {entry[i_cpu_addr[15:12]], i_cpu_addr[11:0]}, combinational from the registered table.
REQ-023 With map_en=0: o_map_addr = {9'b0, i_cpu_addr} (identity).
REQ-024 A commit or map_en write SHALL affect translation from the cycle after the write edge.
REQ-025 A write to the currently executing page is legal; there is no hazard protection.

Reset
REQ-026 On i_arst_n=0 the block SHALL asynchronously set: entry n = n (identity), shadow = 0x00, pending = 0, map_en = 0, wp bits = 0, wp_fault = 0.
REQ-027 Reset between a low write and its high write SHALL discard the staged value; no partial commit.
REQ-028 Deassertion SHALL be synchronised externally; the block assumes a glitch-free release relative to i_clk.

Configuration
REQ-029 Macro MAPPER_WP_EN defined: high-byte bit7 SHALL be stored as the entry wp bit.
REQ-030 With MAPPER_WP_EN: o_wr_block = map_en & i_mem_cs & ~i_rwb & wp of the selected entry (combinational).
REQ-031 With MAPPER_WP_EN: wp_fault SHALL set on each edge where o_wr_block=1.
REQ-032 With MAPPER_WP_EN: a set and a W1C in the same cycle SHALL leave wp_fault = 1.
REQ-033 Without MAPPER_WP_EN: bit7 SHALL be ignored and read 0, o_wr_block = 0, and wp_fault reads 0.

Structure
REQ-034 Package mapper_pkg SHALL hold the constants MAPPER_CTRL_OFFSET=6'h20, PAGE_BITS, OFFSET_BITS=12, and typedef map_entry_t (wp bit + page number).
REQ-035 Sub-module mapper_regfile SHALL contain the entry table, shadow/pending staging and read mux; translation and write-protect logic SHALL stay in the top.

Verification
REQ-036 Reset, map_en=0, i_cpu_addr=0x1234 -> o_map_addr=0x0001234; read offset 0x06 -> 0x03.
REQ-037 Write 0x04=0xAB, then read 0x20 -> 0x02 (pending); write 0x05=0x1F, set map_en, i_cpu_addr=0x2345 -> o_map_addr=0x1FAB345; read 0x20 -> 0x01.
REQ-038 Write 0x04=0x11 then 0x04=0x22, then 0x05=0x00 -> entry2=0x0022; with no further low write, 0x07=0x01 -> entry3=0x0122.
REQ-039 Write 0x00=0x55, assert i_arst_n low mid-sequence, release, write 0x01=0x00 -> entry0=0x0000; read 0x20 -> 0x00.
REQ-040 MAPPER_WP_EN: write 0x1E=0x00, 0x1F=0x80, map_en=1; CPU write to 0xF010 with i_mem_cs=1 -> o_wr_block=1 and 0x20 reads 0x05; write 0x20=0x05 -> 0x20 reads 0x01.
REQ-041 Offsets 0x21 and 0x3F: write 0xFF, read back -> 0x00; all entries unchanged.
